rr_mux_arbiter: RTL

//   Round-robin arbiter that shares one N:1 data mux between N_REQ requesters.

---
 rtl/rr_mux_arbiter_if.sv | 25 ++
 rtl/rr_mux_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if
//   Bundles the requester side (req/in_data/gnt) and the consumer side
//   (out_valid/out_ready/out_data/out_src) of the round-robin mux arbiter.
//   slave  : arbiter view (drives gnt and the output register).
//   master : producers/consumer view (drive req, in_data and out_ready).
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] in_data;
   logic [N_REQ-1:0]        gnt;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic [SEL_W-1:0]        out_src;

   modport slave  (input  req, in_data, out_ready,
                   output gnt, out_valid, out_data, out_src);
   modport master (output req, in_data, out_ready,
                   input  gnt, out_valid, out_data, out_src);
endinterface

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter sharing one N_REQ:1 data mux, feeding a 1-entry
//   output register with a valid/ready handshake.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - rr_mux_arbiter_if.slave:
//                req/in_data : requester words, slice i at [i*DATA_W +: DATA_W]
//                gnt         : one-hot combinational accept
//                out_valid/out_ready/out_data/out_src : output register handshake
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux_arbiter_if.slave  bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                        st;
   logic [SEL_W-1:0]              last_gnt;
   logic [SEL_W-1:0]              src_q;
   logic [DATA_W-1:0]             data_q;
   logic [N_REQ-1:0][DATA_W-1:0]  din;
   logic [SEL_W-1:0]              win;
   logic                          found;
   logic                          slot_free;
   logic                          xfer;
   logic [N_REQ-1:0]              gnt_c;

   assign din       = bus.in_data;
   assign slot_free = (st == EMPTY) | bus.out_ready;
   // Gated by rst_n so gnt reads zero while reset is held, without a clock.
   assign xfer      = rst_n & slot_free & found;

   // Two-pass scan: indices above last_gnt first, then wrap to 0..last_gnt.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && (i > int'(last_gnt)) && bus.req[i]) begin
            found = 1'b1;
            win   = SEL_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && (i <= int'(last_gnt)) && bus.req[i]) begin
            found = 1'b1;
            win   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      gnt_c = '0;
      if (xfer) gnt_c[win] = 1'b1;
   end

   // Output-register FSM. A grant while FULL with out_ready replaces the
   // word on the same edge, giving 1 word/cycle sustained throughput.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= EMPTY;
         data_q   <= '0;
         src_q    <= '0;
         last_gnt <= SEL_W'(N_REQ - 1);
      end else if (xfer) begin
         st       <= FULL;
         data_q   <= din[win];
         src_q    <= win;
         last_gnt <= win;
      end else if ((st == FULL) && bus.out_ready) begin
         st       <= EMPTY;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.out_valid = (st == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;

endmodule
